flood_fill_ctrl: RTL and testbench

//  Sequencer that computes the flood-fill reveal mask for a player reveal on a zero-count tile.

---
 rtl/flood_fill_if.sv | 27 ++
 rtl/flood_fill_ctrl.sv | 131 +++++++++++++
 tb/tb_flood_fill_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/flood_fill_if.sv
// flood_fill_if: handshake and map bundle between the game FSM / tile_state and flood_fill_ctrl
//  master: drives start, start_index and the tile maps; observes busy, flood_update, flood_apply, done
//  slave:  the flood-fill sequencer side
interface flood_fill_if #(
    parameter int GRID_SIZE = 8
);
    localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
    localparam int INDEX_BITS  = $clog2(TOTAL_TILES);
    logic                   start;
    logic [INDEX_BITS-1:0]  start_index;
    logic [TOTAL_TILES-1:0] mine_map;
    logic [TOTAL_TILES-1:0] zero_map;
    logic [TOTAL_TILES-1:0] flagged;
    logic [TOTAL_TILES-1:0] revealed;
    logic                   busy;
    logic [TOTAL_TILES-1:0] flood_update;
    logic                   flood_apply;
    logic                   done;
    modport master (
        output start, start_index, mine_map, zero_map, flagged, revealed,
        input  busy, flood_update, flood_apply, done
    );
    modport slave (
        input  start, start_index, mine_map, zero_map, flagged, revealed,
        output busy, flood_update, flood_apply, done
    );
endinterface

// File: rtl/flood_fill_ctrl.sv
// flood_fill_ctrl: breadth-first flood-fill sequencer producing the reveal mask for a zero-count tile
//  clk, rst (sync, active-high)
//  bus.start/start_index  : flood request and seed tile, accepted only when idle
//  bus.mine_map/zero_map/flagged/revealed : tile maps, held stable while busy
//  bus.busy               : high whenever not idle
//  bus.flood_update       : accumulated reveal mask, held until the next accepted start
//  bus.flood_apply        : one-cycle pulse with flood_update valid
//  bus.done               : one-cycle completion pulse, also issued on a rejected seed
//  Define FLOOD_DIAG_EN for 8-connected search; default is 4-connected.
module flood_fill_ctrl #(
    parameter int GRID_SIZE = 8
) (
    input logic clk,
    input logic rst,
    flood_fill_if.slave bus
);
    localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
    localparam int INDEX_BITS  = $clog2(TOTAL_TILES);
`ifdef FLOOD_DIAG_EN
    localparam int NB = 8;
`else
    localparam int NB = 4;
`endif
    typedef enum logic [2:0] {IDLE, SEED, POP, SCAN, APPLY} state_t;
    state_t                 state;
    logic [INDEX_BITS-1:0]  seed, cur, rd, wr, nidx, push_data;
    logic [INDEX_BITS:0]    cnt;
    logic [2:0]             k;
    logic [TOTAL_TILES-1:0] visited, upd;
    logic [INDEX_BITS-1:0]  fifo [TOTAL_TILES];
    logic                   apply, done_q, abort_q, in_grid, push_ok, seed_bad, push;
    int                     r, c, nr, nc;

    function automatic logic [INDEX_BITS-1:0] nxt(input logic [INDEX_BITS-1:0] p);
        return p == INDEX_BITS'(TOTAL_TILES - 1) ? '0 : p + 1'b1;
    endfunction

    // Neighbour k of the tile being scanned: N, S, W, E, then NW, NE, SW, SE.
    always_comb begin
        r = int'(cur) / GRID_SIZE;
        c = int'(cur) % GRID_SIZE;
`ifdef FLOOD_DIAG_EN
        nr = r + ((k == 3'd0 || k == 3'd4 || k == 3'd5) ? -1 : (k == 3'd1 || k == 3'd6 || k == 3'd7) ? 1 : 0);
        nc = c + ((k == 3'd2 || k == 3'd4 || k == 3'd6) ? -1 : (k == 3'd3 || k == 3'd5 || k == 3'd7) ? 1 : 0);
`else
        nr = r + (k == 3'd0 ? -1 : k == 3'd1 ? 1 : 0);
        nc = c + (k == 3'd2 ? -1 : k == 3'd3 ? 1 : 0);
`endif
        in_grid   = nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE;
        nidx      = in_grid ? INDEX_BITS'(nr * GRID_SIZE + nc) : '0;
        push_ok   = in_grid && !visited[nidx] && !bus.mine_map[nidx] && !bus.flagged[nidx] && !bus.revealed[nidx];
        seed_bad  = bus.mine_map[seed] || bus.flagged[seed];
        push      = (state == SEED && !seed_bad) || (state == SCAN && push_ok);
        push_data = state == SEED ? seed : nidx;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            apply   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            upd     <= '0;
            visited <= '0;
            rd      <= '0;
            wr      <= '0;
            cnt     <= '0;
            k       <= '0;
            seed    <= '0;
            cur     <= '0;
        end else begin
            apply  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    seed    <= bus.start_index;
                    upd     <= '0;
                    visited <= '0;
                    rd      <= '0;
                    wr      <= '0;
                    cnt     <= '0;
                    state   <= SEED;
                end
                // A rejected seed passes through APPLY so done lands one cycle later, with no apply.
                SEED: if (seed_bad) begin
                    abort_q <= 1'b1;
                    state   <= APPLY;
                end else begin
                    state <= POP;
                end
                POP: if (cnt == '0) begin
                    apply  <= 1'b1;
                    done_q <= 1'b1;
                    state  <= APPLY;
                end else begin
                    cur            <= fifo[rd];
                    rd             <= nxt(rd);
                    cnt            <= cnt - 1'b1;
                    upd[fifo[rd]]  <= 1'b1;
                    k              <= '0;
                    if (bus.zero_map[fifo[rd]]) state <= SCAN;
                end
                SCAN: begin
                    k <= k + 1'b1;
                    if (k == 3'(NB - 1)) state <= POP;
                end
                APPLY: begin
                    done_q  <= abort_q;
                    abort_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Marking visited on push bounds total pushes to TOTAL_TILES, so the FIFO never overflows.
            if (push) begin
                wr               <= nxt(wr);
                cnt              <= cnt + 1'b1;
                visited[push_data] <= 1'b1;
            end
        end
    end

    assign bus.busy         = state != IDLE;
    assign bus.flood_update = upd;
    assign bus.flood_apply  = apply;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_flood_fill_ctrl.sv
// tb_flood_fill_ctrl: directed and randomized checks of flood_fill_ctrl against a queue-based BFS model
module tb_flood_fill_ctrl;
    localparam int G = 4;
    localparam int T = G * G;
`ifdef FLOOD_DIAG_EN
    localparam int NB   = 8;
    localparam bit DIAG = 1'b1;
`else
    localparam int NB   = 4;
    localparam bit DIAG = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [T-1:0] obs_mask;
    int obs_lat;

    flood_fill_if #(.GRID_SIZE(G)) ffi ();
    flood_fill_ctrl #(.GRID_SIZE(G)) dut (.clk(clk), .rst(rst), .bus(ffi));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain BFS over the grid from the seed, following the reveal rules directly.
    function automatic void model(input int s, input logic [T-1:0] mn, zr, fl, rv,
                                  output logic [T-1:0] m, output int lat, output bit ab);
        int q[$];
        bit seen[T];
        int p = 0;
        int z = 0;
        m   = '0;
        ab  = mn[s] || fl[s];
        lat = 2;
        if (ab) return;
        q.push_back(s);
        seen[s] = 1'b1;
        while (q.size() > 0) begin
            int t = q.pop_front();
            m[t] = 1'b1;
            p++;
            if (zr[t]) begin
                z++;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        int nr = t / G + dr;
                        int nc = t % G + dc;
                        int n  = nr * G + nc;
                        if ((dr == 0 && dc == 0) || (!DIAG && dr != 0 && dc != 0)) continue;
                        if (nr < 0 || nr >= G || nc < 0 || nc >= G) continue;
                        if (!seen[n] && !mn[n] && !fl[n] && !rv[n]) begin
                            seen[n] = 1'b1;
                            q.push_back(n);
                        end
                    end
            end
        end
        lat = 2 + p + z * NB;
    endfunction

    task automatic set_maps(input logic [T-1:0] mn, zr, fl, rv);
        ffi.mine_map = mn;
        ffi.zero_map = zr;
        ffi.flagged  = fl;
        ffi.revealed = rv;
    endtask

    task automatic launch(input int s);
        @(negedge clk);
        ffi.start_index = 4'(s);
        ffi.start = 1'b1;
        @(negedge clk);
        ffi.start = 1'b0;
    endtask

    // Waits for apply/done after launch; stray_at > 0 injects a start while busy at that cycle.
    task automatic finish(input string tag, input int s, input int stray_at);
        logic [T-1:0] m;
        int lat;
        bit ab;
        int cyc = 0;
        model(s, ffi.mine_map, ffi.zero_map, ffi.flagged, ffi.revealed, m, lat, ab);
        while (!(ffi.flood_apply || ffi.done) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ffi.start = (cyc == stray_at);
            if (cyc == stray_at) ffi.start_index = 4'($urandom_range(T - 1));
        end
        ffi.start = 1'b0;
        obs_lat  = cyc;
        obs_mask = ffi.flood_update;
        check($sformatf("%s.latency", tag), cyc, lat);
        check($sformatf("%s.apply", tag), 32'(ffi.flood_apply), 32'(!ab));
        check($sformatf("%s.done", tag), 32'(ffi.done), 1);
        check($sformatf("%s.mask", tag), 32'(ffi.flood_update), 32'(m));
        @(negedge clk);
        check($sformatf("%s.after_pulses", tag), {ffi.flood_apply, ffi.done, ffi.busy}, 0);
        check($sformatf("%s.mask_held", tag), 32'(ffi.flood_update), 32'(m));
    endtask

    initial begin
        int seen;
        ffi.start = 1'b0;
        ffi.start_index = '0;
        set_maps('0, '0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset.outs", {ffi.busy, ffi.flood_apply, ffi.done}, 0);
        check("reset.mask", 32'(ffi.flood_update), 0);
        rst = 1'b0;

        set_maps('0, '1, '0, '0);
        launch(0);
        finish("full", 0, 0);
        check("full.mask_spec", 32'(obs_mask), 32'h0000FFFF);
        if (!DIAG) check("full.latency_spec", obs_lat, 82);

        set_maps('0, ~16'h0020, '0, '0);
        launch(5);
        finish("nonzero_seed", 5, 0);
        check("nonzero_seed.mask_spec", 32'(obs_mask), 32'h00000020);
        check("nonzero_seed.latency_spec", obs_lat, 3);

        set_maps(16'h0001, '1, '0, '0);
        launch(0);
        finish("mine_seed", 0, 0);
        check("mine_seed.latency_spec", obs_lat, 2);
        set_maps('0, '1, 16'h0001, '0);
        launch(0);
        finish("flag_seed", 0, 0);
        check("flag_seed.mask_spec", 32'(obs_mask), 0);

        set_maps('0, '1, 16'h1111, '0);
        launch(3);
        finish("edge", 3, 0);
        check("edge.mask_spec", 32'(obs_mask), 32'h0000EEEE);

        set_maps(16'h0052, 16'h0021, '0, '0);
        launch(0);
        finish("diag", 0, 0);
        check("diag.mask_spec", 32'(obs_mask), DIAG ? 32'h00000725 : 32'h00000001);
        check("diag.latency_spec", obs_lat, DIAG ? 24 : 7);

        set_maps('0, '1, '0, 16'h0001);
        launch(0);
        finish("revealed_seed", 0, 0);

        set_maps('0, '1, '0, '0);
        launch(0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.outs", {ffi.busy, ffi.flood_apply, ffi.done}, 0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ffi.flood_apply || ffi.done || ffi.busy) seen++;
        end
        check("midreset.quiet", seen, 0);
        launch(0);
        finish("after_reset", 0, 5);
        check("after_reset.mask_spec", 32'(obs_mask), 32'h0000FFFF);

        for (int i = 0; i < 25; i++) begin
            int s = $urandom_range(T - 1);
            set_maps(16'($urandom & $urandom & $urandom), 16'($urandom | $urandom),
                     16'($urandom & $urandom & $urandom & $urandom),
                     16'($urandom & $urandom & $urandom & $urandom));
            launch(s);
            finish($sformatf("rand%0d", i), s, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
